// File: rtl/rs232_rx_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : rs232_rx_fifo_if
// Description : Receiver-side and CPU-side signal bundle for rs232_rx_fifo.
// Revision    : 1.0 - initial release
// ============================================================================
interface rs232_rx_fifo_if #(
  parameter int DEPTH_LOG2 = 4
);
  logic [7:0]            rxData;
  logic                  rxRdy;
  logic                  rxDone;
  logic                  rd;
  logic [7:0]            dout;
  logic                  rdy;
  logic [DEPTH_LOG2:0]   count;
  logic                  ovf;
  logic                  clrOvf;

  modport master (
    output rxData, rxRdy, rd, clrOvf,
    input  rxDone, dout, rdy, count, ovf
  );

  modport slave (
    input  rxData, rxRdy, rd, clrOvf,
    output rxDone, dout, rdy, count, ovf
  );
endinterface
`default_nettype wire

// File: rtl/rs232_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : rs232_rx_fifo
// Description : First-word-fall-through receive FIFO with sticky overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module rs232_rx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  wire logic         clk,
  input  wire logic         rst,
  rs232_rx_fifo_if.slave    bus
);
  localparam int                  DEPTH  = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] c_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [7:0]            r_mem [0:DEPTH-1];
  logic [DEPTH_LOG2-1:0] r_wp;
  logic [DEPTH_LOG2-1:0] r_rp;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_rxDone;
  logic                  r_ovf;

  logic w_full, w_empty, w_cap, w_pop, w_push, w_drop;

  // The rxDone guard stops a second capture while the receiver clears rdy.
  assign w_full  = (r_count == c_FULL);
  assign w_empty = (r_count == '0);
  assign w_cap   = bus.rxRdy & ~r_rxDone;
  assign w_pop   = bus.rd & ~w_empty;
  assign w_push  = w_cap & (~w_full | w_pop);
  assign w_drop  = w_cap & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wp] <= bus.rxData;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp     <= '0;
      r_rp     <= '0;
      r_count  <= '0;
      r_rxDone <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_rxDone <= w_cap;
      if (w_push) begin
        r_wp <= r_wp + DEPTH_LOG2'(1);
      end
      if (w_pop) begin
        r_rp <= r_rp + DEPTH_LOG2'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + (DEPTH_LOG2 + 1)'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - (DEPTH_LOG2 + 1)'(1);
      end
      // A fresh drop outranks a simultaneous clear.
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (bus.clrOvf) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign bus.rxDone = r_rxDone;
  assign bus.dout   = w_empty ? 8'h00 : r_mem[r_rp];
  assign bus.rdy    = ~w_empty;
  assign bus.count  = r_count;
  assign bus.ovf    = r_ovf;
endmodule
`default_nettype wire

// File: tb/tb_rs232_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_rs232_rx_fifo
// Description : Directed self-checking bench for rs232_rx_fifo.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rs232_rx_fifo;
  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   done_cnt;

  rs232_rx_fifo_if #(.DEPTH_LOG2(4)) bus ();

  rs232_rx_fifo #(.DEPTH_LOG2(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.rxDone === 1'b1) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    bus.rxData = 8'h00;
    bus.rxRdy  = 1'b0;
    bus.rd     = 1'b0;
    bus.clrOvf = 1'b0;
    tick();
    rst = 1'b0;
    done_cnt = 0;
  endtask

  task automatic push_byte(input logic [7:0] b);
    bus.rxData = b;
    bus.rxRdy  = 1'b1;
    tick();
    bus.rxRdy  = 1'b0;
    tick();
  endtask

  task automatic fill16();
    for (int i = 0; i < 16; i++) push_byte(8'(i));
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.rdy !== 1'b0 || bus.dout !== 8'h00 || bus.count !== 5'd0 ||
        bus.ovf !== 1'b0 || bus.rxDone !== 1'b0) begin
      errors++;
      $display("FAIL reset: rdy=%b dout=%h count=%0d ovf=%b rxDone=%b, want 0/00/0/0/0",
               bus.rdy, bus.dout, bus.count, bus.ovf, bus.rxDone);
    end
  endtask

  task automatic test_single();
    do_reset();
    bus.rxData = 8'h41;
    bus.rxRdy  = 1'b1;
    tick();
    checks++;
    if (bus.rxDone !== 1'b1 || bus.count !== 5'd1 || bus.rdy !== 1'b1 || bus.dout !== 8'h41) begin
      errors++;
      $display("FAIL single_capture: rxDone=%b count=%0d rdy=%b dout=%h, want 1/1/1/41",
               bus.rxDone, bus.count, bus.rdy, bus.dout);
    end
    bus.rxRdy = 1'b0;
    tick();
    checks++;
    if (bus.rxDone !== 1'b0 || done_cnt != 1) begin
      errors++;
      $display("FAIL single_pulse: rxDone=%b pulses=%0d, want 0 and 1", bus.rxDone, done_cnt);
    end
    bus.rd = 1'b1;
    checks++;
    if (bus.dout !== 8'h41) begin
      errors++;
      $display("FAIL single_dout_at_rd: got %h want 41", bus.dout);
    end
    tick();
    bus.rd = 1'b0;
    checks++;
    if (bus.count !== 5'd0 || bus.rdy !== 1'b0 || bus.dout !== 8'h00) begin
      errors++;
      $display("FAIL single_pop: count=%0d rdy=%b dout=%h, want 0/0/00",
               bus.count, bus.rdy, bus.dout);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    fill16();
    checks++;
    if (bus.count !== 5'd16 || bus.ovf !== 1'b0) begin
      errors++;
      $display("FAIL full: count=%0d ovf=%b, want 16/0", bus.count, bus.ovf);
    end
    bus.rxData = 8'hAA;
    bus.rxRdy  = 1'b1;
    tick();
    checks++;
    if (bus.rxDone !== 1'b1 || bus.ovf !== 1'b1 || bus.count !== 5'd16) begin
      errors++;
      $display("FAIL drop: rxDone=%b ovf=%b count=%0d, want 1/1/16",
               bus.rxDone, bus.ovf, bus.count);
    end
    bus.rxRdy = 1'b0;
    tick();
    for (int i = 0; i < 16; i++) begin
      bus.rd = 1'b1;
      checks++;
      if (bus.dout !== 8'(i)) begin
        errors++;
        $display("FAIL drain[%0d]: got %h want %h", i, bus.dout, 8'(i));
      end
      tick();
    end
    bus.rd = 1'b0;
    checks++;
    if (bus.count !== 5'd0 || bus.rdy !== 1'b0) begin
      errors++;
      $display("FAIL drained: count=%0d rdy=%b, want 0/0", bus.count, bus.rdy);
    end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    fill16();
    bus.rxData = 8'h55;
    bus.rxRdy  = 1'b1;
    bus.rd     = 1'b1;
    checks++;
    if (bus.dout !== 8'h00) begin
      errors++;
      $display("FAIL fullpp_dout: got %h want 00", bus.dout);
    end
    tick();
    bus.rd = 1'b0;
    checks++;
    if (bus.count !== 5'd16 || bus.ovf !== 1'b0 || bus.rxDone !== 1'b1) begin
      errors++;
      $display("FAIL fullpp_state: count=%0d ovf=%b rxDone=%b, want 16/0/1",
               bus.count, bus.ovf, bus.rxDone);
    end
    bus.rxRdy = 1'b0;
    tick();
    for (int i = 1; i <= 16; i++) begin
      bus.rd = 1'b1;
      checks++;
      if (bus.dout !== ((i == 16) ? 8'h55 : 8'(i))) begin
        errors++;
        $display("FAIL fullpp_drain[%0d]: got %h want %h", i, bus.dout,
                 (i == 16) ? 8'h55 : 8'(i));
      end
      tick();
    end
    bus.rd = 1'b0;
  endtask

  task automatic test_rd_empty();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      bus.rd = 1'b1;
      tick();
      bus.rd = 1'b0;
      tick();
    end
    checks++;
    if (bus.count !== 5'd0 || bus.rdy !== 1'b0 || bus.ovf !== 1'b0) begin
      errors++;
      $display("FAIL rd_empty: count=%0d rdy=%b ovf=%b, want 0/0/0",
               bus.count, bus.rdy, bus.ovf);
    end
    push_byte(8'h33);
    checks++;
    if (bus.dout !== 8'h33 || bus.count !== 5'd1) begin
      errors++;
      $display("FAIL rd_empty_push: dout=%h count=%0d, want 33/1", bus.dout, bus.count);
    end
  endtask

  task automatic test_clr_ovf();
    do_reset();
    fill16();
    push_byte(8'hAA);
    bus.rxData = 8'h77;
    bus.rxRdy  = 1'b1;
    bus.clrOvf = 1'b1;
    tick();
    checks++;
    if (bus.ovf !== 1'b1 || bus.count !== 5'd16) begin
      errors++;
      $display("FAIL clr_vs_drop: ovf=%b count=%0d, want 1/16", bus.ovf, bus.count);
    end
    bus.rxRdy = 1'b0;
    tick();
    bus.clrOvf = 1'b0;
    checks++;
    if (bus.ovf !== 1'b0) begin
      errors++;
      $display("FAIL clr_alone: ovf=%b want 0", bus.ovf);
    end
  endtask

  task automatic test_reset_midcapture();
    do_reset();
    bus.rxData = 8'h66;
    bus.rxRdy  = 1'b1;
    rst        = 1'b1;
    tick();
    checks++;
    if (bus.rxDone !== 1'b0 || bus.count !== 5'd0) begin
      errors++;
      $display("FAIL rst_capture: rxDone=%b count=%0d, want 0/0", bus.rxDone, bus.count);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (bus.rxDone !== 1'b1 || bus.count !== 5'd1 || bus.dout !== 8'h66) begin
      errors++;
      $display("FAIL rst_release: rxDone=%b count=%0d dout=%h, want 1/1/66",
               bus.rxDone, bus.count, bus.dout);
    end
    bus.rxRdy = 1'b0;
    tick();
    tick();
    checks++;
    if (done_cnt != 1 || bus.count !== 5'd1) begin
      errors++;
      $display("FAIL rst_pulses: pulses=%0d count=%0d, want 1/1", done_cnt, bus.count);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    done_cnt = 0;
    rst      = 1'b1;
    test_reset();
    test_single();
    test_overflow();
    test_full_push_pop();
    test_rd_empty();
    test_clr_ovf();
    test_reset_midcapture();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/rs232_rx_fifo.md
Name: rs232_rx_fifo

Overview:
Receive-side buffer between the RS-232 receiver (RS232R) and the processor IO bus at word address 2 (data) / 3 (status).
- Drains each byte from the receiver as soon as it is ready, acknowledging it with the receiver's `done` input.
- Stores bytes in a small first-word-fall-through FIFO, so software can fall behind by up to DEPTH bytes without losing characters.
- Provides `rdy`, `count` and a sticky overflow flag for the status word.

Parameters:
DEPTH_LOG2, 4, log2 of FIFO depth; DEPTH = 2**DEPTH_LOG2 entries of 8 bits (16 by default); legal range 1..8.

Ports:
clk  in  1  system clock (25 MHz), all logic on rising edge
rst  in  1  synchronous reset, active-high (one clock; reset is synchronous and active-high)
rxData  in  8  byte from RS232R `data`
rxRdy  in  1  RS232R `rdy`; level, high while a received byte is held
rxDone  out  1  to RS232R `done`; one-cycle acknowledge pulse
rd  in  1  pop strobe, = rd & ioenb & (iowadr == 2), one cycle per CPU load
dout  out  8  head entry, valid in the same cycle `rd` is sampled
rdy  out  1  FIFO not empty
count  out  DEPTH_LOG2+1  number of stored bytes, 0..DEPTH
ovf  out  1  sticky overflow flag
clrOvf  in  1  clears `ovf`, = wr & ioenb & (iowadr == 3) & outbus[1]

Behaviour:
- Storage: DEPTH x 8 array; write pointer `wp` and read pointer `rp`, DEPTH_LOG2 bits each, wrap modulo DEPTH.
- `count` is a separate register; full = (count == DEPTH), empty = (count == 0).
- Capture condition: cap = rxRdy & ~rxDone.
  - `rxDone` is registered: rxDone <= cap.
  - The guard on `rxDone` blocks a second capture of the same byte in the cycle RS232R is still clearing its `rdy`.
  - Back-to-back bytes are therefore captured at most every 2 cycles, far faster than any line rate.
- Push: push = cap & (~full | pop).
  - mem[wp] <= rxData; wp <= wp + 1.
- Drop on full: cap & full & ~pop.
  - The byte is discarded but still acknowledged (`rxDone` pulses), so the receiver never stalls.
  - ovf <= 1.
- Pop: pop = rd & ~empty; rp <= rp + 1.
  - `rd` while empty is ignored: no pointer change, no flag.
- `dout` = mem[rp] when not empty, 8'h00 when empty (combinational from registered state).
  - The CPU samples it in the same cycle as `rd`.
- Count update: +1 on push & ~pop, -1 on pop & ~push, unchanged otherwise.
- Simultaneous events:
  - push & pop when empty: impossible, since pop requires ~empty; the push lands and count goes 0 -> 1.
  - push & pop when full: both occur, count stays DEPTH, no overflow.
  - clrOvf & a new drop in the same cycle: set wins, ovf = 1.
- rdy = ~empty.
- Reset (rst = 1 at a clock edge): wp, rp, count = 0; rxDone = 0; ovf = 0.
  - Outputs after reset: rdy = 0, dout = 0x00, count = 0.
  - Array contents are don't-care.
  - Reset mid-handshake: a pending capture is abandoned. The byte stays in RS232R (rdy still high) and is captured 1 cycle after rst falls.
- Latency: rxRdy rising at cycle n -> byte stored, `rdy` high at n+1, `rxDone` high for cycle n+1 only.

Test Plan:
1. Reset, then rxRdy=1 with rxData=0x41, rxRdy dropped the cycle after rxDone -> exactly one rxDone pulse at n+1; count=1, rdy=1, dout=0x41; rd pulse -> count=0, rdy=0, dout=0x00.
2. Push 0x00..0x0F (16 bytes), no reads -> count=16, ovf=0; push 0xAA -> rxDone pulses, ovf=1, count=16; pop 16 times -> dout sequence 0x00..0x0F, 0xAA never appears.
3. FIFO full; in one cycle rxRdy=1 with 0x55 and rd=1 -> popped 0x00, count stays 16, ovf=0; 16th subsequent pop returns 0x55.
4. rd strobes while empty (5 pulses) -> count=0, rp unchanged, no ovf; a later push of 0x33 reads back 0x33.
5. With ovf=1, assert clrOvf in the same cycle as a full-drop -> ovf stays 1; clrOvf alone next cycle -> ovf=0.
6. rxRdy held high, rst asserted in the capture cycle -> rxDone=0, count=0; rst released -> capture 1 cycle later, count=1, exactly one rxDone.
